// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator (640x480@60 default).
// Ports: clk, rst_n (async low), en in; pix_tick, xcoor, ycoor, active,
// hsync, vsync, line_start, frame_start out.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] xcoor,
  output logic [9:0] ycoor,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       act_nxt;

  assign pix_tick = en && (div_cnt == DIV_LAST);

  always_comb begin
    h_wrap = (xcoor == H_LAST);
    v_wrap = (ycoor == V_LAST);
    x_nxt  = h_wrap ? 10'd0 : xcoor + 10'd1;
    y_nxt  = ycoor;
    if (h_wrap) begin
      y_nxt = v_wrap ? 10'd0 : ycoor + 10'd1;
    end
    // Decode from next values so registered syncs line up with coords.
    hs_nxt  = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
    vs_nxt  = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    act_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 2'd0;
    end else if (en) begin
      div_cnt <= pix_tick ? 2'd0 : div_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xcoor       <= 10'd0;
      ycoor       <= 10'd0;
      active      <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_tick && h_wrap;
      frame_start <= pix_tick && h_wrap && v_wrap;
      if (pix_tick) begin
        xcoor  <= x_nxt;
        ycoor  <= y_nxt;
        active <= act_nxt;
        hsync  <= hs_nxt ? SYNC_POL : ~SYNC_POL;
        vsync  <= vs_nxt ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running 640x480@60 Hz VGA timing generator; first stage of the display pipeline. Produces pixel coordinates (`xcoor`/`ycoor`) consumed by the RAM-backed display stage, plus `hsync`/`vsync` for the connector and single-cycle line/frame markers for game logic. Pixel rate is derived from `clk` by an integer divider so the same block serves 25 MHz and 50 MHz builds.

## Interface
- `H_ACTIVE` 640: visible pixels per line
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal front porch / sync / back porch, pixels
- `V_ACTIVE` 480: visible lines
- `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical front porch / sync / back porch, lines
- `CLK_DIV` 1: `clk` cycles per pixel, legal range 1..4
- `SYNC_POL` 0: asserted level of `hsync`/`vsync` (0 = active-low)

- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: run enable; low freezes all state
- `pix_tick` out 1: high in the cycle at whose end counters advance
- `xcoor` out 10: horizontal count, 0..H_TOTAL-1
- `ycoor` out 10: vertical count, 0..V_TOTAL-1
- `active` out 1: high when `xcoor < H_ACTIVE` and `ycoor < V_ACTIVE`
- `hsync` out 1: horizontal sync at `SYNC_POL` level
- `vsync` out 1: vertical sync at `SYNC_POL` level
- `line_start` out 1: one-`clk` pulse when `xcoor` wraps to 0
- `frame_start` out 1: one-`clk` pulse when (`xcoor`,`ycoor`) wraps to (0,0)

## Operation
- `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP (800); `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div_cnt`, width 2, counts 0..CLK_DIV-1 while `en`=1; `pix_tick` = `en` && (`div_cnt` == CLK_DIV-1), combinational. With CLK_DIV=1, `pix_tick` = `en`.
- On `pix_tick`:
  - `xcoor` increments, wrapping H_TOTAL-1 -> 0.
  - On that horizontal wrap, `ycoor` increments, wrapping V_TOTAL-1 -> 0.
- `hsync`, `vsync` and `active` are registered and update on the same edge as the counters, decoded from the next counter values, so they always match the current `xcoor`/`ycoor`.
- hsync window: x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751. vsync window: y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
- `line_start` and `frame_start` are registered, high for exactly one `clk` cycle, in the cycle after the wrapping edge, regardless of CLK_DIV. `frame_start` implies `line_start`.
- `en`=0: `div_cnt`, counters, syncs and `active` hold; `pix_tick`, `line_start` and `frame_start` are 0. Resuming continues from the held state.
- Reset (async, any time, including mid-line or mid-sync):
  - `div_cnt`=0, `xcoor`=0, `ycoor`=0, `active`=1.
  - `hsync` = `vsync` = !SYNC_POL.
  - `line_start` = `frame_start` = 0.
  - Reset is not a wrap, so no start pulse is emitted on release.

## Timing
- First `pix_tick` occurs in cycle CLK_DIV after `rst_n` deasserts (with `en`=1), counting from cycle 1.
- Coordinate update latency: one `clk` edge after the `pix_tick` cycle. All outputs except `pix_tick` are glitch-free register outputs.
- Line = H_TOTAL ticks; frame = 420000 ticks = 420000*CLK_DIV clks.
- The downstream stage samples `xcoor`/`ycoor` every `clk`. With CLK_DIV>1, each coordinate is stable for CLK_DIV cycles.
- `en` is sampled on `clk` only. A change in `en` takes effect for the divider in the same cycle.

## Test plan
- CLK_DIV=1, en=1, release reset:
  - `xcoor` reaches 799 at tick 799, then returns to 0 and `ycoor` goes to 1 at tick 800.
  - `line_start` is high one cycle at that point.
  - No pulse occurs right after reset.
- Full frame, CLK_DIV=1:
  - 640 `hsync`-asserted pixels are not expected; instead count exactly 96 low ticks per line, starting at x=656.
  - `vsync` is low for lines 490..491 only.
  - `frame_start` pulses once per 420000 cycles, with x=y=0 in that cycle.
- `active` coverage: count `active`=1 cycles over one frame = 307200; `active` falls at x=640 and at y=480.
- CLK_DIV=2:
  - `pix_tick` pattern is 0,1,0,1 from reset.
  - `xcoor` holds each value 2 cycles.
  - Frame length = 840000 cycles.
  - `frame_start` is still 1 cycle wide.
- `en` dropped for 37 cycles at x=655:
  - `xcoor` stays 655 and `hsync` stays deasserted.
  - `pix_tick` is 0 throughout.
  - After `en` rises, the next tick gives x=656 with `hsync` asserted.
- Reset mid-sync:
  - Assert `rst_n`=0 asynchronously at x=700, y=491.
  - Outputs immediately read x=0, y=0, `active`=1, `hsync`=`vsync`=1 with no `clk` edge.
  - Normal count resumes after release.
